// File: rtl/softmax_pkg.sv
// Shared constants, RU stage encodings and controller state for the softmax sequencer.
// Q4.12 fixed point throughout: 4 integer bits (signed), 12 fractional bits.
package softmax_pkg;

    localparam logic [15:0] ONE  = 16'h1000;
    localparam int          FRAC = 12;

    // {ru_sel_mux, ru_sel_mult}
    localparam logic [1:0] STAGE1 = 2'b11;
    localparam logic [1:0] STAGE2 = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXP  = 3'd2,
        S_LOG  = 3'd3,
        S_NORM = 3'd4
    } state_t;

endpackage

// File: rtl/softmax_buf.sv
// N x DW score buffer: one synchronous write port, one asynchronous read port.
// Not reset; contents are only meaningful inside a job.
module softmax_buf #(
    parameter int N  = 64,
    parameter int DW = 16,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/softmax_ctrl.sv
// Softmax sequencer: buffers a score vector, drives the shared RU through the exp and
// normalize stages around a log2 request, and streams the probabilities out.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits on ready, and a source holding valid keeps its data stable.
module softmax_ctrl
    import softmax_pkg::*;
#(
    parameter int N  = 64,
    parameter int DW = 16,
    parameter int AW = $clog2(N + 1),
    parameter int SW = DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] ru_in_0,
    output logic [DW-1:0] ru_in_1,
    output logic          ru_sel_mux,
    output logic          ru_sel_mult,
    input  logic [DW-1:0] ru_out_0,
    input  logic [DW-1:0] ru_out_1,
    output logic          log2_req,
    output logic [SW-1:0] log2_arg,
    input  logic          log2_ack,
    input  logic [DW-1:0] log2_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state_dbg
);

    localparam int IW = $clog2(N);

    state_t        state_q;
    logic [AW-1:0] len_q, idx_q, len_d;
    logic [DW-1:0] max_q, lsum_q, out_data_q, rd_data;
    logic [SW-1:0] sum_q, sum_d;
    logic [SW:0]   sum_ext;
    logic          out_valid_q, out_last_q, done_q;
    logic          last_idx, load_out, buf_we;
    logic [1:0]    sel;

    assign len_d    = (len > AW'(N)) ? AW'(N) : len;
    assign last_idx = (idx_q == len_q - 1'b1);
    assign load_out = (state_q == S_NORM) && (idx_q < len_q) && (!out_valid_q || out_ready);

    // Exponent sum saturates at all-ones instead of wrapping.
    assign sum_ext = {1'b0, sum_q} + (SW + 1)'(ru_out_1);
    assign sum_d   = sum_ext[SW] ? '1 : sum_ext[SW-1:0];

    assign buf_we = ((state_q == S_LOAD) && in_valid) || (state_q == S_EXP);

    softmax_buf #(.N(N), .DW(DW), .IW(IW)) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (idx_q[IW-1:0]),
        .wdata_i ((state_q == S_LOAD) ? in_data : ru_out_0),
        .raddr_i (idx_q[IW-1:0]),
        .rdata_o (rd_data)
    );

    always_comb begin
        ru_in_0 = '0;
        ru_in_1 = '0;
        sel     = STAGE2;
        if (state_q == S_EXP) begin
            ru_in_0 = max_q;
            ru_in_1 = rd_data;
            sel     = STAGE1;
        end else if (state_q == S_NORM) begin
            ru_in_0 = lsum_q;
            ru_in_1 = rd_data;
            sel     = STAGE2;
        end
    end

    assign {ru_sel_mux, ru_sel_mult} = sel;
    assign in_ready  = (state_q == S_LOAD);
    assign log2_req  = (state_q == S_LOG);
    assign log2_arg  = log2_req ? sum_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            max_q       <= '0;
            lsum_q      <= '0;
            sum_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            len_q   <= len_d;
                            idx_q   <= '0;
                            sum_q   <= '0;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (idx_q == '0 || $signed(in_data) > $signed(max_q)) begin
                            max_q <= in_data;
                        end
                        if (last_idx) begin
                            idx_q   <= '0;
                            state_q <= S_EXP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_EXP: begin
                    sum_q <= sum_d;
                    if (last_idx) begin
                        idx_q   <= '0;
                        state_q <= S_LOG;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_LOG: begin
                    if (log2_ack) begin
                        lsum_q  <= log2_res;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    // The load of element i+1 may overlap the drain of element i.
                    if (load_out) begin
                        out_data_q  <= ru_out_1;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_idx;
                        idx_q       <= idx_q + 1'b1;
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_ctrl.sv
// Self-checking bench for softmax_ctrl: ideal RU and log2 models, expected probabilities
// queued from a reference computation and popped on each output handshake.
module tb_softmax_ctrl;
    import softmax_pkg::*;

    localparam int N  = 64;
    localparam int DW = 16;
    localparam int AW = $clog2(N + 1);
    localparam int SW = DW + $clog2(N);
    localparam real LOG2E = 1.4426950408889634;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] len;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] ru_in_0, ru_in_1, ru_out_0, ru_out_1;
    logic          ru_sel_mux, ru_sel_mult;
    logic          log2_req, log2_ack;
    logic [SW-1:0] log2_arg;
    logic [DW-1:0] log2_res;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
    logic          busy, done;
    logic [2:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_q[$];
    logic          last_q[$];
    logic [DW-1:0] vec[N];
    logic [DW-1:0] exp_max;
    logic [SW-1:0] exp_sum;

    int            rdy_mode = 0;
    int            out_cnt = 0, done_cnt = 0, ir_cnt = 0, req_cnt = 0, ov_cnt = 0;
    logic [DW-1:0] last_out_data;
    logic [SW-1:0] last_arg;

    softmax_ctrl #(.N(N), .DW(DW), .AW(AW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ru_in_0(ru_in_0), .ru_in_1(ru_in_1), .ru_sel_mux(ru_sel_mux), .ru_sel_mult(ru_sel_mult),
        .ru_out_0(ru_out_0), .ru_out_1(ru_out_1),
        .log2_req(log2_req), .log2_arg(log2_arg), .log2_ack(log2_ack), .log2_res(log2_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference models ----------------
    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic real ru_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
        int d;
        d = int'($signed(b)) - int'($signed(a));
        return (real'(d) / real'(1 << FRAC)) * (s ? LOG2E : 1.0);
    endfunction

    function automatic logic [15:0] ru_mult(input logic [15:0] a, input logic [15:0] b, input logic s);
        return 16'(sat16($rtoi(ru_prod(a, b, s) * 4096.0)));
    endfunction

    function automatic logic [15:0] ru_pow2(input logic [15:0] a, input logic [15:0] b, input logic s);
        real r;
        r = (2.0 ** ru_prod(a, b, s)) * 4096.0 + 0.5;
        return 16'(sat16($rtoi(r)));
    endfunction

    function automatic logic [15:0] log2_model(input logic [SW-1:0] a);
        real r;
        r = 0.0;
        if (a != '0) r = $ln(real'(a) / 4096.0) / $ln(2.0) * 4096.0;
        r = (r >= 0.0) ? r + 0.5 : r - 0.5;
        return 16'(sat16($rtoi(r)));
    endfunction

    always_comb begin
        ru_out_0 = ru_mult(ru_in_0, ru_in_1, ru_sel_mult);
        ru_out_1 = ru_pow2(ru_in_0, ru_in_1, ru_sel_mult);
    end

    task automatic model_job(input int l);
        logic [15:0] m;
        logic [15:0] y[N];
        logic [SW:0] s;
        logic [15:0] ls;
        m = vec[0];
        for (int i = 1; i < l; i++) if ($signed(vec[i]) > $signed(m)) m = vec[i];
        s = '0;
        for (int i = 0; i < l; i++) begin
            y[i] = ru_mult(m, vec[i], 1'b1);
            s = s + (SW + 1)'(ru_pow2(m, vec[i], 1'b1));
            if (s[SW]) s = {1'b0, {SW{1'b1}}};
        end
        exp_max = m;
        exp_sum = s[SW-1:0];
        ls = log2_model(exp_sum);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(ru_pow2(ls, y[i], 1'b0));
            last_q.push_back(i == l - 1);
        end
    endtask

    // ---------------- log2 unit: acks after a few cycles ----------------
    initial begin
        int lwait;
        lwait = 0;
        log2_ack = 1'b0;
        log2_res = '0;
        forever begin
            @(negedge clk);
            if (log2_ack) begin
                log2_ack = 1'b0;
            end else if (log2_req) begin
                if (lwait == 3) begin
                    check_eq("log2_arg", log2_arg, exp_sum);
                    last_arg = log2_arg;
                    log2_res = log2_model(log2_arg);
                    log2_ack = 1'b1;
                    lwait = 0;
                end else begin
                    lwait++;
                end
            end
        end
    end

    // ---------------- output sink / scoreboard / monitors ----------------
    initial begin
        logic          stall, stall_last, prev_req;
        logic [DW-1:0] stall_data;
        logic [SW-1:0] prev_arg;
        stall = 1'b0;
        stall_last = 1'b0;
        stall_data = '0;
        prev_req = 1'b0;
        prev_arg = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = (rdy_mode == 0) ? 1'b1 : ~out_ready;
            if (out_valid && stall) begin
                check_eq("stall_data", out_data, stall_data);
                check_eq("stall_last", out_last, stall_last);
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                last_out_data = out_data;
                if (exp_q.size() == 0) begin
                    check_eq("extra_out", 1, 0);
                end else begin
                    check_eq("out_data", out_data, exp_q.pop_front());
                    check_eq("out_last", out_last, last_q.pop_front());
                end
                stall = 1'b0;
            end else if (out_valid) begin
                stall = 1'b1;
                stall_data = out_data;
                stall_last = out_last;
            end else begin
                stall = 1'b0;
            end
            if (state_dbg == 3'(S_EXP)) begin
                check_eq("exp_ru_in_0", ru_in_0, exp_max);
                check_eq("exp_sel", {ru_sel_mux, ru_sel_mult}, STAGE1);
            end
            if (log2_req && prev_req) check_eq("log2_arg_stable", log2_arg, prev_arg);
            prev_req = log2_req;
            prev_arg = log2_arg;
            if (done) begin
                done_cnt++;
                check_eq("busy_at_done", busy, 0);
            end
            if (in_ready) ir_cnt++;
            if (log2_req) req_cnt++;
            if (out_valid) ov_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_job(input int l);
        @(negedge clk);
        start = 1'b1;
        len = AW'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_range(input int a, input int b);
        for (int i = a; i < b; i++) begin
            int t;
            t = 0;
            in_valid = 1'b1;
            in_data = vec[i];
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) check_eq("in_ready_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check_eq("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_checks(input string tag, input int l, input int d0, input int o0);
        check_eq({tag, "_done_once"}, done_cnt - d0, 1);
        check_eq({tag, "_out_count"}, out_cnt - o0, l);
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_job(input string tag, input int l);
        int d0, o0;
        model_job(l);
        d0 = done_cnt;
        o0 = out_cnt;
        start_job(l);
        load_range(0, l);
        wait_done();
        finish_checks(tag, l, d0, o0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, o0, i0, r0, v0;
        rst_n = 1'b0;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {in_ready, log2_req, out_valid, out_last, busy, done}, 0);
        check_eq("reset_data", {out_data, ru_in_0, ru_in_1, ru_sel_mux, ru_sel_mult}, 0);
        check_eq("reset_arg", log2_arg, 0);
        rst_n = 1'b1;

        // Uniform scores: probability 1/4 each
        for (int i = 0; i < 4; i++) vec[i] = ONE;
        run_job("t1", 4);
        check_eq("t1_log2_arg", last_arg, 22'h4000);
        check_eq("t1_prob", last_out_data, ONE >> 2);

        // Max is the second element
        vec[0] = 16'h1000;
        vec[1] = 16'h2400;
        run_job("t2", 2);

        // Zero length: done one cycle after start, nothing else moves
        d0 = done_cnt; i0 = ir_cnt; r0 = req_cnt; v0 = ov_cnt;
        start_job(0);
        check_eq("len0_done", done, 1);
        check_eq("len0_busy", busy, 0);
        repeat (4) @(negedge clk);
        check_eq("len0_done_once", done_cnt - d0, 1);
        check_eq("len0_quiet", {32'(ir_cnt - i0), 32'(req_cnt - r0), 32'(ov_cnt - v0)}, 0);

        // Random scores with output backpressure
        for (int i = 0; i < 8; i++) vec[i] = 16'($urandom_range(0, 16'h3000)) - 16'h1800;
        rdy_mode = 1;
        run_job("t4", 8);
        rdy_mode = 0;

        // Asynchronous reset mid-EXP aborts the job
        for (int i = 0; i < 4; i++) vec[i] = 16'($urandom_range(0, 16'h2000));
        model_job(4);
        start_job(4);
        load_range(0, 4);
        check_eq("t5_in_exp", state_dbg, 3'(S_EXP));
        #1 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_ctrl", {in_ready, log2_req, out_valid, out_last, busy, done}, 0);
        check_eq("t5_rst_data", {out_data, ru_in_0, ru_in_1, ru_sel_mux, ru_sel_mult}, 0);
        exp_q.delete();
        last_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        vec[0] = 16'hF000;
        run_job("t5", 1);
        check_eq("t5_prob", last_out_data, ONE);

        // start during LOAD with another len is ignored
        for (int i = 0; i < 5; i++) vec[i] = 16'($urandom_range(0, 16'h2000));
        model_job(5);
        d0 = done_cnt;
        o0 = out_cnt;
        start_job(5);
        load_range(0, 1);
        start = 1'b1;
        len = AW'(2);
        @(negedge clk);
        start = 1'b0;
        load_range(1, 5);
        wait_done();
        finish_checks("t6", 5, d0, o0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
